// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: ALU op codes, R-type funct codes,
// forwarding / destination selects and mul/div FSM states.
package ex_pkg;

  typedef enum logic [2:0] {
    ALU_OP_RTYPE = 3'b000,
    ALU_OP_ADD   = 3'b001,
    ALU_OP_AND   = 3'b010,
    ALU_OP_OR    = 3'b011,
    ALU_OP_XOR   = 3'b100,
    ALU_OP_SLT   = 3'b101,
    ALU_OP_LUI   = 3'b110,
    ALU_OP_SLTU  = 3'b111
  } alu_op_e;

  localparam logic [5:0] FUNCT_SLL   = 6'h00;
  localparam logic [5:0] FUNCT_SRL   = 6'h02;
  localparam logic [5:0] FUNCT_SRA   = 6'h03;
  localparam logic [5:0] FUNCT_SLLV  = 6'h04;
  localparam logic [5:0] FUNCT_SRLV  = 6'h06;
  localparam logic [5:0] FUNCT_SRAV  = 6'h07;
  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;
  localparam logic [5:0] FUNCT_ADDU  = 6'h21;
  localparam logic [5:0] FUNCT_SUBU  = 6'h23;
  localparam logic [5:0] FUNCT_AND   = 6'h24;
  localparam logic [5:0] FUNCT_OR    = 6'h25;
  localparam logic [5:0] FUNCT_XOR   = 6'h26;
  localparam logic [5:0] FUNCT_NOR   = 6'h27;
  localparam logic [5:0] FUNCT_SLT   = 6'h2A;
  localparam logic [5:0] FUNCT_SLTU  = 6'h2B;

  localparam logic [1:0] FWD_ID_EX  = 2'b00;
  localparam logic [1:0] FWD_EX_MEM = 2'b01;
  localparam logic [1:0] FWD_MEM_WB = 2'b10;

  localparam logic [1:0] SRC_B_BUS  = 2'b00;
  localparam logic [1:0] SRC_B_IMMS = 2'b01;
  localparam logic [1:0] SRC_B_IMMU = 2'b10;
  localparam logic [1:0] SRC_B_UPP  = 2'b11;

  localparam logic [1:0] REG_DST_RT  = 2'b00;
  localparam logic [1:0] REG_DST_RD  = 2'b01;
  localparam logic [1:0] REG_DST_R31 = 2'b10;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_BUSY = 2'b01,
    MD_DONE = 2'b10
  } md_state_e;

  // Low two funct bits of MULT..DIVU select the operation.
  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  function automatic logic is_muldiv_funct(input logic [5:0] funct);
    return funct inside {FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU};
  endfunction

endpackage

// File: rtl/ex_muldiv.sv
// Iterative multiply/divide unit: one shift-add or restoring-subtract step per
// enabled cycle, owning HI/LO. Only instantiated when EX_MULDIV_EN is defined.
module ex_muldiv
  import ex_pkg::*;
#(
  parameter int BUS_SIZE = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                enable_i,
  input  logic                start_i,
  input  md_op_e              op_i,
  input  logic [BUS_SIZE-1:0] op_a_i,
  input  logic [BUS_SIZE-1:0] op_b_i,
  input  logic                mthi_i,
  input  logic                mtlo_i,
  output logic [BUS_SIZE-1:0] hi_o,
  output logic [BUS_SIZE-1:0] lo_o,
  output logic                stall_o
);

  localparam int W  = BUS_SIZE;
  localparam int CW = $clog2(BUS_SIZE);
  localparam logic [CW-1:0] LAST = CW'(BUS_SIZE - 1);

  md_state_e       state_q;
  md_op_e          op_q;
  logic [CW-1:0]   cnt_q;
  logic            sign_a_q, sign_b_q, div0_q;
  logic [W-1:0]    opnd_q, a_raw_q;
  logic [2*W-1:0]  acc_q;
  logic [W-1:0]    hi_q, lo_q;

  logic            signed_op, a_neg, b_neg, is_mul;
  logic [W-1:0]    a_abs, b_abs;
  logic [W:0]      add_sum, shl;
  logic [W-1:0]    rem_sub;
  logic [2*W-1:0]  step_res, prod;
  logic [W-1:0]    fin_hi, fin_lo;

  assign signed_op = (op_i == MD_MULT) || (op_i == MD_DIV);
  assign a_neg     = signed_op && op_a_i[W-1];
  assign b_neg     = signed_op && op_b_i[W-1];
  assign a_abs     = a_neg ? -op_a_i : op_a_i;
  assign b_abs     = b_neg ? -op_b_i : op_b_i;
  assign is_mul    = (op_q == MD_MULT) || (op_q == MD_MULTU);

  // acc holds {partial product, multiplier} for mul and {remainder, quotient} for div.
  assign add_sum = {1'b0, acc_q[2*W-1:W]} + {1'b0, opnd_q};
  assign shl     = {acc_q[2*W-1:W], acc_q[W-1]};
  assign rem_sub = W'(shl - {1'b0, opnd_q});

  always_comb begin
    step_res = '0;
    if (is_mul) begin
      step_res = acc_q[0] ? {add_sum, acc_q[W-1:1]} : {1'b0, acc_q[2*W-1:1]};
    end else if (shl >= {1'b0, opnd_q}) begin
      step_res = {rem_sub, acc_q[W-2:0], 1'b1};
    end else begin
      step_res = {shl[W-1:0], acc_q[W-2:0], 1'b0};
    end
  end

  always_comb begin
    prod   = (sign_a_q ^ sign_b_q) ? -step_res : step_res;
    fin_hi = prod[2*W-1:W];
    fin_lo = prod[W-1:0];
    if (!is_mul) begin
      if (div0_q) begin
        fin_lo = '1;
        fin_hi = a_raw_q;
      end else begin
        fin_lo = (sign_a_q ^ sign_b_q) ? -step_res[W-1:0] : step_res[W-1:0];
        fin_hi = sign_a_q ? -step_res[2*W-1:W] : step_res[2*W-1:W];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= MD_IDLE;
      op_q     <= MD_MULT;
      cnt_q    <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      div0_q   <= 1'b0;
      opnd_q   <= '0;
      a_raw_q  <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else if (enable_i) begin
      case (state_q)
        MD_IDLE: begin
          if (start_i) begin
            op_q     <= op_i;
            sign_a_q <= a_neg;
            sign_b_q <= b_neg;
            div0_q   <= (op_b_i == '0);
            opnd_q   <= b_abs;
            a_raw_q  <= op_a_i;
            acc_q    <= {{W{1'b0}}, a_abs};
            cnt_q    <= '0;
            state_q  <= MD_BUSY;
          end else begin
            if (mthi_i) hi_q <= op_a_i;
            if (mtlo_i) lo_q <= op_a_i;
          end
        end
        MD_BUSY: begin
          acc_q <= step_res;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            hi_q    <= fin_hi;
            lo_q    <= fin_lo;
            state_q <= MD_DONE;
          end
        end
        MD_DONE: begin
          if (mthi_i) hi_q <= op_a_i;
          if (mtlo_i) lo_q <= op_a_i;
          state_q <= MD_IDLE;
        end
        default: state_q <= MD_IDLE;
      endcase
    end
  end

  assign stall_o = (state_q == MD_BUSY) || ((state_q == MD_IDLE) && start_i);
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, destination select and store data.
// Define EX_MULDIV_EN to add the iterative mul/div unit, HI/LO and MF*/MT*.
module ex_stage
  import ex_pkg::*;
#(
  parameter int BUS_SIZE = 32
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_enable,
  input  logic                i_alu_src_a,
  input  logic [1:0]          i_alu_src_b,
  input  logic [2:0]          i_alu_op,
  input  logic [1:0]          i_reg_dst,
  input  logic [5:0]          i_funct,
  input  logic [5:0]          i_op,
  input  logic [BUS_SIZE-1:0] i_bus_a,
  input  logic [BUS_SIZE-1:0] i_bus_b,
  input  logic [4:0]          i_rt,
  input  logic [4:0]          i_rd,
  input  logic [BUS_SIZE-1:0] i_shamt_ext_unsigned,
  input  logic [BUS_SIZE-1:0] i_inm_ext_signed,
  input  logic [BUS_SIZE-1:0] i_inm_ext_unsigned,
  input  logic [BUS_SIZE-1:0] i_inm_upp,
  input  logic [1:0]          i_fwd_a,
  input  logic [1:0]          i_fwd_b,
  input  logic [BUS_SIZE-1:0] i_ex_mem_result,
  input  logic [BUS_SIZE-1:0] i_mem_wb_result,
  output logic [BUS_SIZE-1:0] o_result,
  output logic [BUS_SIZE-1:0] o_store_data,
  output logic [4:0]          o_wr_reg,
  output logic                o_stall
);

  localparam int SHW = $clog2(BUS_SIZE);

  logic [BUS_SIZE-1:0] fwd_a, fwd_b, op_a, op_b, alu_res;
  logic [SHW-1:0]      shamt;

`ifdef EX_MULDIV_EN
  logic [BUS_SIZE-1:0] hi, lo;
  logic                rtype_op0, md_start, mthi, mtlo;
`endif

  always_comb begin
    case (i_fwd_a)
      FWD_EX_MEM: fwd_a = i_ex_mem_result;
      FWD_MEM_WB: fwd_a = i_mem_wb_result;
      default:    fwd_a = i_bus_a;
    endcase
    case (i_fwd_b)
      FWD_EX_MEM: fwd_b = i_ex_mem_result;
      FWD_MEM_WB: fwd_b = i_mem_wb_result;
      default:    fwd_b = i_bus_b;
    endcase
    case (i_alu_src_b)
      SRC_B_IMMS: op_b = i_inm_ext_signed;
      SRC_B_IMMU: op_b = i_inm_ext_unsigned;
      SRC_B_UPP:  op_b = i_inm_upp;
      default:    op_b = fwd_b;
    endcase
  end

  assign op_a  = i_alu_src_a ? i_shamt_ext_unsigned : fwd_a;
  assign shamt = op_a[SHW-1:0];

  always_comb begin
    // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
    alu_res = '0;
    case (alu_op_e'(i_alu_op))
      ALU_OP_RTYPE: begin
        case (i_funct)
          FUNCT_SLL, FUNCT_SLLV: alu_res = op_b << shamt;
          FUNCT_SRL, FUNCT_SRLV: alu_res = op_b >> shamt;
          FUNCT_SRA, FUNCT_SRAV: alu_res = $unsigned($signed(op_b) >>> shamt);
          FUNCT_ADDU:            alu_res = op_a + op_b;
          FUNCT_SUBU:            alu_res = op_a - op_b;
          FUNCT_AND:             alu_res = op_a & op_b;
          FUNCT_OR:              alu_res = op_a | op_b;
          FUNCT_XOR:             alu_res = op_a ^ op_b;
          FUNCT_NOR:             alu_res = ~(op_a | op_b);
          FUNCT_SLT:  alu_res = {{(BUS_SIZE-1){1'b0}}, $signed(op_a) < $signed(op_b)};
          FUNCT_SLTU: alu_res = {{(BUS_SIZE-1){1'b0}}, op_a < op_b};
`ifdef EX_MULDIV_EN
          FUNCT_MFHI:            alu_res = hi;
          FUNCT_MFLO:            alu_res = lo;
`endif
          default:               alu_res = '0;
        endcase
      end
      ALU_OP_ADD:  alu_res = op_a + op_b;
      ALU_OP_AND:  alu_res = op_a & op_b;
      ALU_OP_OR:   alu_res = op_a | op_b;
      ALU_OP_XOR:  alu_res = op_a ^ op_b;
      ALU_OP_SLT:  alu_res = {{(BUS_SIZE-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      ALU_OP_LUI:  alu_res = op_b;
      ALU_OP_SLTU: alu_res = {{(BUS_SIZE-1){1'b0}}, op_a < op_b};
    endcase
  end

  always_comb begin
    case (i_reg_dst)
      REG_DST_RD:  o_wr_reg = i_rd;
      REG_DST_R31: o_wr_reg = 5'd31;
      default:     o_wr_reg = i_rt;
    endcase
  end

  assign o_result     = alu_res;
  assign o_store_data = fwd_b;

`ifdef EX_MULDIV_EN
  assign rtype_op0 = (i_alu_op == ALU_OP_RTYPE) && (i_op == 6'd0);
  assign md_start  = rtype_op0 && is_muldiv_funct(i_funct);
  assign mthi      = rtype_op0 && (i_funct == FUNCT_MTHI);
  assign mtlo      = rtype_op0 && (i_funct == FUNCT_MTLO);

  ex_muldiv #(.BUS_SIZE(BUS_SIZE)) u_muldiv (
    .clk_i    (i_clk),
    .rst_ni   (i_reset_n),
    .enable_i (i_enable),
    .start_i  (md_start),
    .op_i     (md_op_e'(i_funct[1:0])),
    .op_a_i   (fwd_a),
    .op_b_i   (fwd_b),
    .mthi_i   (mthi),
    .mtlo_i   (mtlo),
    .hi_o     (hi),
    .lo_o     (lo),
    .stall_o  (o_stall)
  );
`else
  // Without the mul/div unit the stage is purely combinational.
  logic unused_md;
  assign unused_md = ^{i_clk, i_reset_n, i_enable, i_op};
  assign o_stall   = 1'b0;
`endif

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: table-driven ALU/forwarding vectors through a
// scoreboard queue, plus mul/div latency, enable-pause and reset sequences.
module tb_ex_stage;
  import ex_pkg::*;

  localparam int W = 32;

  logic         i_clk = 1'b0;
  logic         i_reset_n, i_enable, i_alu_src_a;
  logic [1:0]   i_alu_src_b, i_reg_dst, i_fwd_a, i_fwd_b;
  logic [2:0]   i_alu_op;
  logic [5:0]   i_funct, i_op;
  logic [W-1:0] i_bus_a, i_bus_b, i_shamt_ext_unsigned, i_inm_ext_signed;
  logic [W-1:0] i_inm_ext_unsigned, i_inm_upp, i_ex_mem_result, i_mem_wb_result;
  logic [4:0]   i_rt, i_rd;
  logic [W-1:0] o_result, o_store_data;
  logic [4:0]   o_wr_reg;
  logic         o_stall;

  always #5 i_clk = ~i_clk;

  ex_stage #(.BUS_SIZE(W)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_enable(i_enable),
    .i_alu_src_a(i_alu_src_a), .i_alu_src_b(i_alu_src_b), .i_alu_op(i_alu_op),
    .i_reg_dst(i_reg_dst), .i_funct(i_funct), .i_op(i_op),
    .i_bus_a(i_bus_a), .i_bus_b(i_bus_b), .i_rt(i_rt), .i_rd(i_rd),
    .i_shamt_ext_unsigned(i_shamt_ext_unsigned), .i_inm_ext_signed(i_inm_ext_signed),
    .i_inm_ext_unsigned(i_inm_ext_unsigned), .i_inm_upp(i_inm_upp),
    .i_fwd_a(i_fwd_a), .i_fwd_b(i_fwd_b),
    .i_ex_mem_result(i_ex_mem_result), .i_mem_wb_result(i_mem_wb_result),
    .o_result(o_result), .o_store_data(o_store_data), .o_wr_reg(o_wr_reg),
    .o_stall(o_stall)
  );

  typedef struct {
    string        name;
    logic [2:0]   alu_op;
    logic [5:0]   funct;
    logic         src_a;
    logic [1:0]   src_b, fwd_a, fwd_b, reg_dst;
    logic [W-1:0] a, b, aux, exp_res;
  } vec_t;

  typedef struct {
    string        name;
    logic [W-1:0] res, store;
    logic [4:0]   wr;
    logic         stall;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic [2:0] op, input logic [5:0] f,
                              input logic sa, input logic [1:0] sb, input logic [1:0] fa,
                              input logic [1:0] fb, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] aux, input logic [1:0] rd,
                              input logic [W-1:0] exp_res);
    vec_t v;
    v.name = name; v.alu_op = op; v.funct = f; v.src_a = sa; v.src_b = sb;
    v.fwd_a = fa; v.fwd_b = fb; v.a = a; v.b = b; v.aux = aux; v.reg_dst = rd;
    v.exp_res = exp_res;
    return v;
  endfunction

  // aux feeds every side input (forwarded results, shamt, immediates).
  task automatic drive_vec(input vec_t v);
    exp_t e;
    i_alu_op = v.alu_op; i_funct = v.funct; i_op = 6'd0;
    i_alu_src_a = v.src_a; i_alu_src_b = v.src_b;
    i_fwd_a = v.fwd_a; i_fwd_b = v.fwd_b; i_reg_dst = v.reg_dst;
    i_bus_a = v.a; i_bus_b = v.b;
    i_ex_mem_result = v.aux; i_mem_wb_result = v.aux; i_shamt_ext_unsigned = v.aux;
    i_inm_ext_signed = v.aux; i_inm_ext_unsigned = v.aux; i_inm_upp = v.aux;
    i_rt = 5'd3; i_rd = 5'd9;
    e.name  = v.name;
    e.res   = v.exp_res;
    e.store = (v.fwd_b == 2'b01 || v.fwd_b == 2'b10) ? v.aux : v.b;
    e.wr    = (v.reg_dst == 2'b00) ? 5'd3 : (v.reg_dst == 2'b01) ? 5'd9 : 5'd31;
    e.stall = 1'b0;
    sb_q.push_back(e);
  endtask

  task automatic observe();
    exp_t e;
    @(negedge i_clk);
    if (sb_q.size() == 0) begin
      check("scoreboard empty", 1, 0);
    end else begin
      e = sb_q.pop_front();
      check({e.name, " result"}, o_result, e.res);
      check({e.name, " store"},  o_store_data, e.store);
      check({e.name, " wr_reg"}, {27'd0, o_wr_reg}, {27'd0, e.wr});
      check({e.name, " stall"},  {31'd0, o_stall}, {31'd0, e.stall});
    end
  endtask

  task automatic rtype(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    drive_vec(mk("rtype", ALU_OP_RTYPE, f, 1'b0, 2'b00, 2'b00, 2'b00, a, b, '0, 2'b01, '0));
    void'(sb_q.pop_back());
  endtask

  task automatic issue(input string name, input logic [5:0] f, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] exp_res);
    @(posedge i_clk); #1;
    drive_vec(mk(name, ALU_OP_RTYPE, f, 1'b0, 2'b00, 2'b00, 2'b00, a, b, '0, 2'b01, exp_res));
    observe();
  endtask

`ifdef EX_MULDIV_EN
  // Counts stalled cycles of one mul/div; optionally drops enable for 5 cycles.
  task automatic md_run(input string name, input logic [5:0] f, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int pause_at, input int exp_cycles);
    int n = 0;
    bit done = 1'b0;
    @(posedge i_clk); #1;
    rtype(f, a, b);
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge i_clk);
      if (o_stall) begin
        n++;
        i_enable = !(pause_at > 0 && n >= pause_at && n < pause_at + 5);
      end else begin
        done = 1'b1;
      end
    end
    i_enable = 1'b1;
    check({name, " stall cycles"}, n, exp_cycles);
  endtask
`endif

  initial begin
    int n;
    vecs.push_back(mk("addu",      ALU_OP_RTYPE, FUNCT_ADDU, 0, 2'b00, 2'b00, 2'b00, 32'h7, 32'hFFFFFFFF, 32'h0, 2'b01, 32'h6));
    vecs.push_back(mk("addu_fwd",  ALU_OP_RTYPE, FUNCT_ADDU, 0, 2'b00, 2'b01, 2'b00, 32'h7, 32'hFFFFFFFF, 32'h10, 2'b01, 32'h0F));
    vecs.push_back(mk("sra",       ALU_OP_RTYPE, FUNCT_SRA,  1, 2'b00, 2'b00, 2'b00, 32'h0, 32'h80000000, 32'h4, 2'b01, 32'hF8000000));
    vecs.push_back(mk("sltu",      ALU_OP_RTYPE, FUNCT_SLTU, 0, 2'b00, 2'b00, 2'b00, 32'h1, 32'hFFFFFFFF, 32'h0, 2'b01, 32'h1));
    vecs.push_back(mk("slt",       ALU_OP_RTYPE, FUNCT_SLT,  0, 2'b00, 2'b00, 2'b00, 32'h1, 32'hFFFFFFFF, 32'h0, 2'b01, 32'h0));
    vecs.push_back(mk("subu_fwdb", ALU_OP_RTYPE, FUNCT_SUBU, 0, 2'b00, 2'b00, 2'b10, 32'h3, 32'h77, 32'h5, 2'b01, 32'hFFFFFFFE));
    vecs.push_back(mk("addi",      ALU_OP_ADD,   6'h00,      0, 2'b01, 2'b00, 2'b00, 32'h10, 32'h55, 32'hFFFFFFFC, 2'b00, 32'hC));
    vecs.push_back(mk("lui",       ALU_OP_LUI,   6'h00,      0, 2'b11, 2'b00, 2'b00, 32'h1, 32'h2, 32'hABCD0000, 2'b10, 32'hABCD0000));
    vecs.push_back(mk("ori",       ALU_OP_OR,    6'h00,      0, 2'b10, 2'b00, 2'b00, 32'h0F0F0000, 32'h0, 32'h0000F0F0, 2'b00, 32'h0F0FF0F0));
    vecs.push_back(mk("nor",       ALU_OP_RTYPE, FUNCT_NOR,  0, 2'b00, 2'b00, 2'b00, 32'h0F0F0F0F, 32'h00FF00FF, 32'h0, 2'b01, 32'hF000F000));
    vecs.push_back(mk("sllv_mask", ALU_OP_RTYPE, FUNCT_SLLV, 0, 2'b00, 2'b00, 2'b00, 32'h24, 32'h1, 32'h0, 2'b01, 32'h10));
    vecs.push_back(mk("bad_funct", ALU_OP_RTYPE, 6'h3F,      0, 2'b00, 2'b00, 2'b00, 32'h5, 32'h6, 32'h0, 2'b01, 32'h0));
    vecs.push_back(mk("fwd11",     ALU_OP_RTYPE, FUNCT_ADDU, 0, 2'b00, 2'b11, 2'b11, 32'h2, 32'h3, 32'h100, 2'b01, 32'h5));
    vecs.push_back(mk("srl31",     ALU_OP_RTYPE, FUNCT_SRL,  1, 2'b00, 2'b00, 2'b00, 32'h0, 32'h80000000, 32'h1F, 2'b01, 32'h1));
    vecs.push_back(mk("xor",       ALU_OP_XOR,   6'h00,      0, 2'b00, 2'b00, 2'b00, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0, 2'b00, 32'hF00FF00F));
    vecs.push_back(mk("slti",      ALU_OP_SLT,   6'h00,      0, 2'b01, 2'b00, 2'b00, 32'hFFFFFFFF, 32'h0, 32'h1, 2'b00, 32'h1));
    vecs.push_back(mk("sltiu",     ALU_OP_SLTU,  6'h00,      0, 2'b01, 2'b00, 2'b00, 32'hFFFFFFFF, 32'h0, 32'h1, 2'b00, 32'h0));
    vecs.push_back(mk("andi",      ALU_OP_AND,   6'h00,      0, 2'b10, 2'b00, 2'b00, 32'h12345678, 32'h0, 32'h0000FFFF, 2'b00, 32'h5678));
    vecs.push_back(mk("sll0",      ALU_OP_RTYPE, FUNCT_SLL,  1, 2'b00, 2'b00, 2'b00, 32'h0, 32'hDEADBEEF, 32'h0, 2'b01, 32'hDEADBEEF));

    i_reset_n = 1'b0;
    i_enable  = 1'b1;
    rtype(FUNCT_SLL, '0, '0);
    #1;
    check("reset stall", {31'd0, o_stall}, 0);
    check("reset result", o_result, 0);
    repeat (2) @(posedge i_clk);
    #1 i_reset_n = 1'b1;

    foreach (vecs[i]) begin
      @(posedge i_clk); #1;
      drive_vec(vecs[i]);
      observe();
    end

`ifdef EX_MULDIV_EN
    md_run("mult", FUNCT_MULT, 32'hFFFFFFFE, 32'h3, 0, 33);
    issue("mfhi_mult", FUNCT_MFHI, 0, 0, 32'hFFFFFFFF);
    issue("mflo_mult", FUNCT_MFLO, 0, 0, 32'hFFFFFFFA);
    md_run("div", FUNCT_DIV, 32'hFFFFFFF9, 32'h2, 0, 33);
    issue("mflo_div", FUNCT_MFLO, 0, 0, 32'hFFFFFFFD);
    issue("mfhi_div", FUNCT_MFHI, 0, 0, 32'hFFFFFFFF);
    md_run("divu0", FUNCT_DIVU, 32'h5, 32'h0, 0, 33);
    issue("mflo_divu0", FUNCT_MFLO, 0, 0, 32'hFFFFFFFF);
    issue("mfhi_divu0", FUNCT_MFHI, 0, 0, 32'h5);
    md_run("multu_pause", FUNCT_MULTU, 32'h2, 32'h3, 10, 38);
    issue("mflo_pause", FUNCT_MFLO, 0, 0, 32'h6);
    @(posedge i_clk); #1;
    rtype(FUNCT_MTHI, 32'hCAFEBABE, 0);
    issue("mfhi_mthi", FUNCT_MFHI, 0, 0, 32'hCAFEBABE);

    // Abort a multiply mid-flight; HI/LO must come back cleared.
    @(posedge i_clk); #1;
    rtype(FUNCT_MULT, 32'h2, 32'h3);
    for (int k = 0; k < 10; k++) @(negedge i_clk);
    check("busy before reset", {31'd0, o_stall}, 1);
    i_reset_n = 1'b0;
    rtype(FUNCT_SLL, '0, '0);
    #1;
    check("stall on reset", {31'd0, o_stall}, 0);
    @(posedge i_clk); #1 i_reset_n = 1'b1;
    issue("mflo_after_reset", FUNCT_MFLO, 0, 0, 32'h0);
    issue("mfhi_after_reset", FUNCT_MFHI, 0, 0, 32'hCAFEBABE & 32'h0);
`else
    issue("mult_nomd", FUNCT_MULT, 32'h2, 32'h3, 32'h0);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge i_clk);
      if (o_stall) n++;
    end
    check("nomd stall cycles", n, 0);
    @(posedge i_clk); #1;
    rtype(FUNCT_MTLO, 32'h1234, 0);
    issue("mflo_nomd", FUNCT_MFLO, 0, 0, 32'h0);
    issue("mfhi_nomd", FUNCT_MFHI, 0, 0, 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
